mult6_share_ctrl: RTL and testbench

//  Shares one combinational 6x6 approximate multiplier datapath (partial products,

---
 rtl/mult6_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 17 +
 rtl/mult6_share_ctrl.sv | 122 ++++++++++++
 tb/tb_mult6_share_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult6_pkg.sv
// mult6_pkg: shared widths and delay-line entry type for the 6x6 multiplier share controller
package mult6_pkg;
  localparam int OP_W = 6;
  localparam int PROD_W = 12;
  localparam int TAG_MAX_W = 3;
  typedef logic [TAG_MAX_W-1:0] tag_t;
  typedef struct packed {
    logic              valid;
    tag_t              tag;
    logic [PROD_W-1:0] prod;
  } dl_entry_t;
  function automatic int tag_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr, wrapping
module rr_arbiter #(
  parameter int N = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);
  logic [N-1:0] hi, pick;
  always_comb begin
    hi = '0;
    for (int i = 0; i < N; i++) hi[i] = req[i] & (i >= int'(ptr));
    pick = |hi ? hi : req;
    gnt = pick & (~pick + N'(1));
  end
endmodule

// File: rtl/mult6_share_ctrl.sv
// mult6_share_ctrl: round-robin sharing of one 6x6 multiplier datapath with tagged per-requester responses
module mult6_share_ctrl
  import mult6_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PIPE_LAT = 1,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [OP_W*NUM_REQ-1:0]   req_a,
  input  logic [OP_W*NUM_REQ-1:0]   req_b,
  input  logic [NUM_REQ-1:0]        req_approx,
  output logic [OP_W-1:0]           mul_a,
  output logic [OP_W-1:0]           mul_b,
  output logic                      mul_approx,
  output logic                      mul_valid,
  input  logic [PROD_W-1:0]         mul_p,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [PROD_W*NUM_REQ-1:0] rsp_data,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [NUM_REQ-1:0]        busy,
  output logic [CNT_W-1:0]          op_cnt
);
  localparam int TAG_W = tag_w(NUM_REQ);
  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt, busy_q, busy_d, rsp_valid_q, rsp_valid_d;
  logic [PROD_W*NUM_REQ-1:0] rsp_data_q, rsp_data_d;
  logic [OP_W-1:0] a_d, b_d, mul_a_q, mul_b_q;
  logic approx_d, mul_approx_q, mul_valid_q, acc;
  tag_t gidx, mul_tag_q;
  logic [CNT_W-1:0] op_cnt_q;
  dl_entry_t dl_in, arr;

  rr_arbiter #(.N(NUM_REQ), .PTR_W(TAG_W)) u_arb (
    .req(req_valid & ~busy_q),
    .ptr(ptr_q),
    .gnt(gnt)
  );

  assign dl_in = '{valid: mul_valid_q, tag: mul_tag_q, prod: mul_p};

  // The response slot is the final delay stage, so PIPE_LAT-1 extra registers precede it.
  if (PIPE_LAT > 1) begin : g_dl
    dl_entry_t dl_q [PIPE_LAT-1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < PIPE_LAT-1; k++) dl_q[k] <= '0;
      end else begin
        dl_q[0] <= dl_in;
        for (int k = 1; k < PIPE_LAT-1; k++) dl_q[k] <= dl_q[k-1];
      end
    end
    assign arr = dl_q[PIPE_LAT-2];
  end else begin : g_nodl
    assign arr = dl_in;
  end

  always_comb begin
    acc = |gnt;
    gidx = '0;
    a_d = '0;
    b_d = '0;
    approx_d = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gidx = tag_t'(i);
        a_d = req_a[i*OP_W +: OP_W];
        b_d = req_b[i*OP_W +: OP_W];
        approx_d = req_approx[i];
      end
    end
    ptr_d = !acc ? ptr_q : int'(gidx) == NUM_REQ-1 ? '0 : TAG_W'(gidx + tag_t'(1));
    busy_d = (busy_q | gnt) & ~(rsp_valid_q & rsp_ready);
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_data_d = rsp_data_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arr.valid && arr.tag == tag_t'(i)) begin
        rsp_valid_d[i] = 1'b1;
        rsp_data_d[i*PROD_W +: PROD_W] = arr.prod;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      busy_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      mul_approx_q <= 1'b0;
      mul_valid_q <= 1'b0;
      mul_tag_q <= '0;
      op_cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      busy_q <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      mul_a_q <= a_d;
      mul_b_q <= b_d;
      mul_approx_q <= approx_d;
      mul_valid_q <= acc;
      mul_tag_q <= gidx;
      if (acc) op_cnt_q <= op_cnt_q + CNT_W'(1);
    end
  end

  assign req_ready = gnt;
  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;
  assign mul_approx = mul_approx_q;
  assign mul_valid = mul_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign busy = busy_q;
  assign op_cnt = op_cnt_q;
endmodule

// File: tb/tb_mult6_share_ctrl.sv
// tb_mult6_share_ctrl: scoreboard bench for the shared multiplier controller (PIPE_LAT 1 and 3 instances)
module tb_mult6_share_ctrl;
  localparam int N = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_approx = '0, rsp_ready = '0;
  logic [6*N-1:0] req_a = '0, req_b = '0;
  logic [N-1:0] req_ready, rsp_valid, busy, req_ready3, rsp_valid3, busy3;
  logic [5:0] mul_a, mul_b, mul_a3, mul_b3;
  logic mul_approx, mul_valid, mul_approx3, mul_valid3;
  logic [11:0] mul_p, mul_p3;
  logic [12*N-1:0] rsp_data, rsp_data3;
  logic [15:0] op_cnt, op_cnt3;
  int n_cmp = 0, n_err = 0;

  typedef struct packed {
    logic [1:0]  tag;
    logic [11:0] prod;
  } sb_t;
  sb_t sb[$];

  function automatic logic [11:0] mul_model(input logic [5:0] a, input logic [5:0] b, input logic ap);
    logic [11:0] p;
    p = {6'b0, a} * {6'b0, b};
    return ap ? (p & 12'hFFC) : p;
  endfunction

  assign mul_p = mul_model(mul_a, mul_b, mul_approx);
  assign mul_p3 = mul_model(mul_a3, mul_b3, mul_approx3);

  mult6_share_ctrl #(.NUM_REQ(N), .PIPE_LAT(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_approx(req_approx),
    .mul_a(mul_a), .mul_b(mul_b), .mul_approx(mul_approx), .mul_valid(mul_valid), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy), .op_cnt(op_cnt)
  );

  mult6_share_ctrl #(.NUM_REQ(N), .PIPE_LAT(3), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready3),
    .req_a(req_a), .req_b(req_b), .req_approx(req_approx),
    .mul_a(mul_a3), .mul_b(mul_b3), .mul_approx(mul_approx3), .mul_valid(mul_valid3), .mul_p(mul_p3),
    .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .rsp_ready(rsp_ready), .busy(busy3), .op_cnt(op_cnt3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [5:0] a, input logic [5:0] b, input logic ap);
    req_a[6*i +: 6] = a;
    req_b[6*i +: 6] = b;
    req_approx[i] = ap;
  endtask

  task automatic do_reset();
    tick();
    req_valid = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Scoreboard for the PIPE_LAT=1 instance: push on accept, match by tag on response handshake.
  always @(negedge clk) begin
    int idx;
    sb_t e;
    if (!rst_n) sb.delete();
    else begin
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          idx = -1;
          for (int k = 0; k < sb.size(); k++) if (idx < 0 && sb[k].tag == 2'(i)) idx = k;
          chk("rsp_pending", 64'(idx >= 0), 1);
          if (idx >= 0) begin
            chk("rsp_data", rsp_data[12*i +: 12], sb[idx].prod);
            sb.delete(idx);
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.tag = 2'(i);
          e.prod = mul_model(req_a[6*i +: 6], req_b[6*i +: 6], req_approx[i]);
          sb.push_back(e);
        end
      end
    end
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, cnt, cyc;
    bit done;
    rsp_ready = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_mvalid", mul_valid, 0);
    chk("rst_mops", {mul_a, mul_b, mul_approx}, 0);
    chk("rst_rsp", {rsp_valid, rsp_data}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", op_cnt, 0);
    tick();
    rst_n = 1'b1;
    // 1: single exact op, latency PIPE_LAT+1
    tick();
    set_op(0, 6'd63, 6'd63, 1'b0);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t1_mvalid", mul_valid, 1);
    chk("t1_mops", {mul_a, mul_b}, {6'd63, 6'd63});
    chk("t1_cnt", op_cnt, 1);
    chk("t1_busy", busy, 4'b0001);
    chk("t1_rsp_early", rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 4'b0001);
    chk("t1_rsp_data", rsp_data[11:0], 12'd3969);
    chk("t1_busy_hs", busy, 4'b0001);
    chk("t1_mvalid_off", {mul_valid, mul_a, mul_b, mul_approx}, 0);
    tick();
    @(negedge clk);
    chk("t1_busy_clr", busy, 0);
    chk("t1_rsp_clr", rsp_valid, 0);
    // 2: all requesters valid, grants rotate 0..3 with back-to-back issue
    do_reset();
    for (int k = 0; k < N; k++) set_op(k, 6'(13*k+20), 6'(63-9*k), k == 2);
    req_valid = 4'b1111;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk("t2_grant", req_ready, 64'(1 << k));
      if (k > 0) begin
        chk("t2_mvalid", mul_valid, 1);
        chk("t2_mul_a", mul_a, 64'(13*(k-1)+20));
        chk("t2_mapprox", mul_approx, 64'(k-1 == 2));
      end
      tick();
    end
    req_valid = '0;
    @(negedge clk);
    chk("t2_mvalid4", mul_valid, 1);
    chk("t2_mul_a4", mul_a, 59);
    tick();
    @(negedge clk);
    chk("t2_idle", {mul_valid, mul_a, mul_b, mul_approx}, 0);
    // 3: response held while rsp_ready[1] low
    repeat (4) tick();
    rsp_ready = 4'b1101;
    set_op(1, 6'd37, 6'd29, 1'b0);
    req_valid = 4'b0010;
    w = 0;
    @(negedge clk);
    while (!req_ready[1] && w < 20) begin
      tick();
      @(negedge clk);
      w++;
    end
    chk("t3_grant", req_ready[1], 1);
    tick();
    tick();
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("t3_hold_valid", rsp_valid[1], 1);
      chk("t3_hold_data", rsp_data[23:12], 12'd1073);
      chk("t3_no_regrant", req_ready[1], 0);
      tick();
    end
    rsp_ready = 4'b1111;
    req_valid = '0;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("t3_busy_clr", busy[1], 0);
    chk("t3_rsp_clr", rsp_valid, 0);
    // 4: reset with two ops outstanding
    tick();
    rsp_ready = '0;
    set_op(0, 6'd7, 6'd9, 1'b0);
    set_op(2, 6'd11, 6'd3, 1'b0);
    req_valid = 4'b0101;
    @(negedge clk);
    chk("t4_grant_a", req_ready, 4'b0100);
    tick();
    @(negedge clk);
    chk("t4_grant_b", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t4_inflight", busy, 4'b0101);
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    rsp_ready = '1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("t4_no_rsp", rsp_valid, 0);
      chk("t4_no_busy", busy, 0);
      chk("t4_no_rsp3", rsp_valid3, 0);
      tick();
    end
    req_valid = 4'b1111;
    @(negedge clk);
    chk("t4_grant0", req_ready, 4'b0001);
    chk("t4_grant0_p3", req_ready3, 4'b0001);
    tick();
    req_valid = '0;
    // 5: PIPE_LAT=3 instance, tags kept apart
    repeat (6) tick();
    set_op(2, 6'd0, 6'd45, 1'b0);
    set_op(3, 6'd1, 6'd1, 1'b0);
    req_valid = 4'b1100;
    @(negedge clk);
    chk("t5_grant2", req_ready3, 4'b0100);
    tick();
    @(negedge clk);
    chk("t5_grant3", req_ready3, 4'b1000);
    tick();
    req_valid = '0;
    for (int j = 2; j < 4; j++) begin
      @(negedge clk);
      chk("t5_early", rsp_valid3, 0);
      tick();
    end
    @(negedge clk);
    chk("t5_rsp2_valid", rsp_valid3, 4'b0100);
    chk("t5_rsp2_data", rsp_data3[35:24], 0);
    chk("t5_rsp3_empty", rsp_data3[47:36], 0);
    tick();
    @(negedge clk);
    chk("t5_rsp3_valid", rsp_valid3, 4'b1000);
    chk("t5_rsp3_data", rsp_data3[47:36], 1);
    // 6: op_cnt wrap after 2^16 accepts
    do_reset();
    rsp_ready = '1;
    for (int k = 0; k < N; k++) set_op(k, 6'($urandom), 6'($urandom), 1'($urandom));
    req_valid = 4'b1111;
    cnt = 0;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 80000) begin
      @(negedge clk);
      cnt += $countones(req_valid & req_ready);
      cyc++;
      if (cnt == 65536) begin
        chk("t6_cnt_max", op_cnt, 16'hFFFF);
        done = 1'b1;
      end else begin
        tick();
        for (int k = 0; k < N; k++) set_op(k, 6'($urandom), 6'($urandom), 1'($urandom));
      end
    end
    chk("t6_done", done, 1);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t6_wrap", op_cnt, 0);
    repeat (8) tick();
    @(negedge clk);
    chk("t6_drain_busy", busy, 0);
    chk("t6_drain_rsp", rsp_valid, 0);
    chk("t6_sb_empty", sb.size(), 0);
    tick();
    set_op(0, 6'd5, 6'd6, 1'b0);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t6_after_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t6_after_cnt", op_cnt, 1);
    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
